// File: rtl/sum_display_driver_if.sv
// Sum capture/display bus between the adder-side controller and the display driver.
interface sum_display_driver_if;
  logic [4:0] sum_in;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  modport master (output sum_in, load, input busy, seg, dig_sel);
  modport slave  (input sum_in, load, output busy, seg, dig_sel);
endinterface

// File: rtl/sum_display_driver.sv
// Captures a 5-bit sum, converts it to BCD with a sequential double-dabble engine
// and time-multiplexes the two digits onto a shared 7-segment bus.
module sum_display_driver #(
  parameter int unsigned REFRESH_DIV  = 1024,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  sum_display_driver_if.slave bus
);
  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t        state, state_next;
  logic [4:0]    shift;
  logic [7:0]    bcd, bcd_adj, bcd_next;
  logic [2:0]    iter;
  logic [3:0]    tens, ones, digit;
  logic [CW-1:0] refresh_cnt;
  logic          digit_idx;
  logic [6:0]    seg_raw;
  logic [1:0]    dsel_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.load) state_next = CONVERT;
      CONVERT: if (iter == 3'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add-3 correction on each nibble, then shift {bcd,shift} left.
  always_comb begin
    bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    bcd_next     = {bcd_adj[6:0], shift[4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      bcd   <= '0;
      iter  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (ena) begin
      if (state == IDLE) begin
        if (bus.load) begin
          shift <= bus.sum_in;
          bcd   <= '0;
          iter  <= 3'd5;
        end
      end else begin
        shift <= {shift[3:0], 1'b0};
        bcd   <= bcd_next;
        iter  <= iter - 3'd1;
        // Display only takes the finished result, never intermediate scratch.
        if (iter == 3'd1) begin
          tens <= bcd_next[7:4];
          ones <= bcd_next[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= 1'b0;
    end else if (ena) begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= ~digit_idx;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    digit = digit_idx ? tens : ones;
    case (digit)
      4'd0:    seg_raw = 7'h3F;
      4'd1:    seg_raw = 7'h06;
      4'd2:    seg_raw = 7'h5B;
      4'd3:    seg_raw = 7'h4F;
      4'd4:    seg_raw = 7'h66;
      4'd5:    seg_raw = 7'h6D;
      4'd6:    seg_raw = 7'h7D;
      4'd7:    seg_raw = 7'h07;
      4'd8:    seg_raw = 7'h7F;
      4'd9:    seg_raw = 7'h6F;
      default: seg_raw = 7'h00;
    endcase
    if (digit_idx && tens == 4'd0) seg_raw = 7'h00;
    dsel_raw    = digit_idx ? 2'b10 : 2'b01;
    bus.busy    = (state == CONVERT);
    bus.seg     = COMMON_ANODE ? ~seg_raw  : seg_raw;
    bus.dig_sel = COMMON_ANODE ? ~dsel_raw : dsel_raw;
  end
endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: common-cathode and common-anode instances driven
// in lockstep and compared against an arithmetic reference model.
module tb_sum_display_driver;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [4:0] sum_in_v = '0;
  logic       load_v = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model state: value being converted, cycles of busy left,
  // value on display, and number of enabled cycles since reset.
  int m_cap, m_busy_cnt, m_disp, m_ticks;

  sum_display_driver_if bus0 ();
  sum_display_driver_if bus1 ();

  assign bus0.sum_in = sum_in_v;
  assign bus0.load   = load_v;
  assign bus1.sum_in = sum_in_v;
  assign bus1.load   = load_v;

  sum_display_driver #(.REFRESH_DIV(DIV), .COMMON_ANODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0.slave));
  sum_display_driver #(.REFRESH_DIV(DIV), .COMMON_ANODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1.slave));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] value;
    logic [6:0] tens_seg;
    logic [6:0] ones_seg;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] table_v[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return table_v[d];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_busy_cnt = 0; m_disp = 0; m_ticks = 0;
  endtask

  task automatic model_step();
    if (!ena) return;
    m_ticks++;
    if (m_busy_cnt == 0) begin
      if (load_v) begin
        m_cap      = int'(sum_in_v);
        m_busy_cnt = 5;
      end
    end else begin
      m_busy_cnt--;
      if (m_busy_cnt == 0) m_disp = m_cap;
    end
  endtask

  task automatic check_model();
    int         idx, t, o;
    logic [6:0] es, es_inv;
    logic [1:0] ed, ed_inv;
    idx = (m_ticks / DIV) % 2;
    t   = m_disp / 10;
    o   = m_disp % 10;
    if (idx == 0) begin
      ed = 2'b01; es = seg_of(o);
    end else begin
      ed = 2'b10; es = (t == 0) ? 7'h00 : seg_of(t);
    end
    es_inv = ~es;
    ed_inv = ~ed;
    check("busy_cc", {15'b0, bus0.busy}, {15'b0, m_busy_cnt != 0});
    check("seg_cc",  {9'b0, bus0.seg}, {9'b0, es});
    check("dsel_cc", {14'b0, bus0.dig_sel}, {14'b0, ed});
    check("busy_ca", {15'b0, bus1.busy}, {15'b0, m_busy_cnt != 0});
    check("seg_ca",  {9'b0, bus1.seg}, {9'b0, es_inv});
    check("dsel_ca", {14'b0, bus1.dig_sel}, {14'b0, ed_inv});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_phase(input logic [1:0] want);
    int unsigned n = 0;
    while (bus0.dig_sel !== want && n < 3 * DIV) begin
      tick();
      n++;
    end
    check("phase_wait", {15'b0, bus0.dig_sel === want}, 16'd1);
  endtask

  // One-cycle load pulse, then measure how long busy stays high.
  task automatic load_value(input logic [4:0] v);
    int unsigned n = 0;
    sum_in_v = v;
    load_v   = 1'b1;
    tick();
    load_v   = 1'b0;
    while (bus0.busy === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    check("busy_len", 16'(n), 16'd5);
  endtask

  task automatic check_display(input logic [6:0] tens_seg, input logic [6:0] ones_seg);
    wait_phase(2'b01);
    check("ones_seg", {9'b0, bus0.seg}, {9'b0, ones_seg});
    wait_phase(2'b10);
    check("tens_seg", {9'b0, bus0.seg}, {9'b0, tens_seg});
  endtask

  initial begin
    vecs[0] = '{5'd23, 7'h5B, 7'h4F};
    vecs[1] = '{5'd7,  7'h00, 7'h07};
    vecs[2] = '{5'd10, 7'h06, 7'h3F};
    vecs[3] = '{5'd0,  7'h00, 7'h3F};
    vecs[4] = '{5'd29, 7'h5B, 7'h6F};
    vecs[5] = '{5'd15, 7'h06, 7'h6D};
    vecs[6] = '{5'd26, 7'h5B, 7'h7D};
    vecs[7] = '{5'd18, 7'h06, 7'h7F};

    // Reset state and refresh cadence with blanked leading zero.
    model_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dsel", {14'b0, bus0.dig_sel}, 16'h0001);
    check("rst_seg",  {9'b0, bus0.seg}, 16'h003F);
    check("rst_busy", {15'b0, bus0.busy}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) tick();
    check("t1_dsel_tens", {14'b0, bus0.dig_sel}, 16'h0002);
    check("t1_seg_blank", {9'b0, bus0.seg}, 16'h0000);
    repeat (4) tick();
    check("t1_dsel_ones", {14'b0, bus0.dig_sel}, 16'h0001);

    foreach (vecs[i]) begin
      load_value(vecs[i].value);
      check_display(vecs[i].tens_seg, vecs[i].ones_seg);
    end

    // Load held high during busy cycles 2..5 must not disturb the conversion of 31.
    load_value(5'd31);
    check_display(7'h4F, 7'h06);
    sum_in_v = 5'd31;
    load_v   = 1'b1;
    tick();
    load_v   = 1'b0;
    tick();
    sum_in_v = 5'd0;
    load_v   = 1'b1;
    repeat (4) tick();
    load_v   = 1'b0;
    check("t3_busy_done", {15'b0, bus0.busy}, 16'h0000);
    check_display(7'h4F, 7'h06);

    // Asynchronous reset in the middle of busy cycle 3.
    sum_in_v = 5'd19;
    load_v   = 1'b1;
    tick();
    load_v   = 1'b0;
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_rst_dsel", {14'b0, bus0.dig_sel}, 16'h0001);
    check("t5_rst_seg",  {9'b0, bus0.seg}, 16'h003F);
    check("t5_rst_busy", {15'b0, bus0.busy}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    load_value(5'd19);
    check_display(7'h06, 7'h6F);

    // Common-anode view of 5, then freeze with ena low.
    load_value(5'd5);
    wait_phase(2'b01);
    check("t6_ca_dsel", {14'b0, bus1.dig_sel}, 16'h0002);
    check("t6_ca_seg",  {9'b0, bus1.seg}, 16'h0012);
    ena = 1'b0;
    sum_in_v = 5'd27;
    load_v   = 1'b1;
    repeat (10) begin
      tick();
      check("t6_frozen_seg", {9'b0, bus1.seg}, 16'h0012);
    end
    load_v = 1'b0;
    ena    = 1'b1;
    repeat (3) tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      ena      = ($urandom_range(9, 0) != 0);
      load_v   = ($urandom_range(4, 0) == 0);
      sum_in_v = 5'($urandom_range(31, 0));
      tick();
    end
    load_v = 1'b0;
    ena    = 1'b1;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
